axi_rr_sequencer: RTL and testbench

Round-robin command sequencer that shares one struct-based AXI4 master port between NumReq simple requesters. Each requester issues single-word read/write commands over a valid/ready interface. The block arbitrates, drives one single-beat AXI4 transaction at a time (AW+W then B, or AR then R), and returns the read data and error status to the granted requester. It sits between the accelerator configuration/control masters and the AXI crossbar port.

---
 rtl/axi_rr_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_rr_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_sequencer.sv
// Round-robin sequencer: funnels single-word read/write commands from NumReq
// requesters onto one AXI4 master port, one single-beat transaction at a time.
package axi_rr_sequencer_pkg;
    localparam int unsigned AxiAddrWidth = 48;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiIdWidth   = 4;
    localparam int unsigned AxiUserWidth = 1;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [AxiUserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0]   data;
        logic [AxiDataWidth/8-1:0] strb;
        logic                      last;
        logic [AxiUserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [AxiUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [AxiUserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;
endpackage

// state        | meaning
// IDLE         | arbitrate, grant and latch one command
// WR_ADDR_DATA | AW and W outstanding, each drops after its own handshake
// WR_RESP      | waiting for B
// RD_ADDR      | AR outstanding
// RD_DATA      | waiting for R
// RESP         | one-cycle completion pulse to the granted requester
module axi_rr_sequencer #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter type req_t  = axi_rr_sequencer_pkg::req_t,
    parameter type resp_t = axi_rr_sequencer_pkg::resp_t
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq-1:0]               req_we_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_strb_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            rsp_err_o,
    output req_t                            axi_req_o,
    input  resp_t                           axi_rsp_i
);
    localparam int unsigned IdxWidth  = $clog2(NumReq);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam logic [2:0]  AxiSize   = 3'($clog2(StrbWidth));

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_e;

    state_e                 state_q;
    logic [IdxWidth-1:0]    ptr_q;
    logic [IdxWidth-1:0]    idx_q;
    logic                   gnt_valid;
    logic [IdxWidth-1:0]    gnt_idx;
    logic [IdxWidth-1:0]    ptr_next;
    int                     cand;
    logic                   sel_we;
    logic [AddrWidth-1:0]   sel_addr;
    logic [DataWidth-1:0]   sel_wdata;
    logic [StrbWidth-1:0]   sel_strb;
    logic                   wr_done;
    logic                   unused_rsp;

    // Search starts at the pointer so the last winner has lowest priority.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        if (state_q == IDLE && !rst_i) begin
            for (int i = 0; i < int'(NumReq); i++) begin
                cand = (int'(ptr_q) + i) % int'(NumReq);
                if (!gnt_valid && req_valid_i[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IdxWidth'(cand);
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            if (IdxWidth'(k) == gnt_idx) begin
                sel_we    = req_we_i[k];
                sel_addr  = req_addr_i[k*AddrWidth +: AddrWidth];
                sel_wdata = req_wdata_i[k*DataWidth +: DataWidth];
                sel_strb  = req_strb_i[k*StrbWidth +: StrbWidth];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (gnt_valid) req_ready_o[gnt_idx] = 1'b1;
    end

    assign ptr_next = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    // A valid that is already low counts as a completed handshake.
    assign wr_done  = (!axi_req_o.aw_valid || axi_rsp_i.aw_ready) &&
                      (!axi_req_o.w_valid  || axi_rsp_i.w_ready);
    assign unused_rsp = ^axi_rsp_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            axi_req_o   <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        idx_q <= gnt_idx;
                        ptr_q <= ptr_next;
                        if (sel_we) begin
                            axi_req_o.aw.id    <= IdWidth'(gnt_idx);
                            axi_req_o.aw.addr  <= sel_addr;
                            axi_req_o.aw.len   <= 8'd0;
                            axi_req_o.aw.size  <= AxiSize;
                            axi_req_o.aw.burst <= 2'b01;
                            axi_req_o.w.data   <= sel_wdata;
                            axi_req_o.w.strb   <= sel_strb;
                            axi_req_o.w.last   <= 1'b1;
                            axi_req_o.aw_valid <= 1'b1;
                            axi_req_o.w_valid  <= 1'b1;
                            state_q            <= WR_ADDR_DATA;
                        end else begin
                            axi_req_o.ar.id    <= IdWidth'(gnt_idx);
                            axi_req_o.ar.addr  <= sel_addr;
                            axi_req_o.ar.len   <= 8'd0;
                            axi_req_o.ar.size  <= AxiSize;
                            axi_req_o.ar.burst <= 2'b01;
                            axi_req_o.ar_valid <= 1'b1;
                            state_q            <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (axi_rsp_i.aw_ready) axi_req_o.aw_valid <= 1'b0;
                    if (axi_rsp_i.w_ready)  axi_req_o.w_valid  <= 1'b0;
                    if (wr_done) begin
                        axi_req_o.b_ready <= 1'b1;
                        state_q           <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_rsp_i.b_valid) begin
                        axi_req_o.b_ready <= 1'b0;
                        rsp_valid_o       <= NumReq'(1) << idx_q;
                        rsp_rdata_o       <= '0;
                        rsp_err_o         <= axi_rsp_i.b.resp[1];
                        state_q           <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (axi_rsp_i.ar_ready) begin
                        axi_req_o.ar_valid <= 1'b0;
                        axi_req_o.r_ready  <= 1'b1;
                        state_q            <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_rsp_i.r_valid) begin
                        axi_req_o.r_ready <= 1'b0;
                        rsp_valid_o       <= NumReq'(1) << idx_q;
                        rsp_rdata_o       <= axi_rsp_i.r.data;
                        rsp_err_o         <= axi_rsp_i.r.resp[1];
                        state_q           <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response IDs are not used functionally; flag a mismatch in simulation.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (axi_req_o.b_ready && axi_rsp_i.b_valid) |-> axi_rsp_i.b.id == IdWidth'(idx_q));
    assert property (@(posedge clk_i) disable iff (rst_i)
        (axi_req_o.r_ready && axi_rsp_i.r_valid) |-> axi_rsp_i.r.id == IdWidth'(idx_q));

endmodule

// File: tb/tb_axi_rr_sequencer.sv
// Bench for axi_rr_sequencer: scripted requesters, a parameterised-delay AXI slave and a
// per-cycle channel-obligation model, plus literal expectations per scenario.
module tb_axi_rr_sequencer;
    import axi_rr_sequencer_pkg::*;

    localparam int NR = 2;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req_valid = '0;
    logic [NR-1:0]       req_we = '0;
    logic [NR*AW-1:0]    req_addr = '0;
    logic [NR*DW-1:0]    req_wdata = '0;
    logic [NR*SW-1:0]    req_strb = '0;
    logic [NR-1:0]       req_ready;
    logic [NR-1:0]       rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;
    req_t                axi_req;
    resp_t               axi_rsp = '0;

    always #5 clk = ~clk;

    axi_rr_sequencer #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .IdWidth(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .axi_req_o(axi_req), .axi_rsp_i(axi_rsp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave delays and response values
    int aw_dly = 0, w_dly = 0, ar_dly = 0, bv_dly = 0, rv_dly = 0;
    logic [1:0]    b_resp_k = 2'b00;
    logic [1:0]    r_resp_k = 2'b00;
    logic [DW-1:0] r_data_k = '0;

    // slave state
    int sl_aw_wait = 0, sl_w_wait = 0, sl_ar_wait = 0, sl_b_wait = 0, sl_r_wait = 0;
    logic sl_aw_done = 0, sl_w_done = 0, sl_b_pend = 0, sl_r_pend = 0;
    logic [3:0]    sl_aw_id = '0, sl_ar_id = '0, sl_b_id = '0;
    logic [AW-1:0] sl_aw_addr = '0, sl_ar_addr = '0;
    logic [7:0]    sl_aw_len = '0;
    logic [2:0]    sl_aw_size = '0;
    logic          sl_w_last = 0;
    logic [DW-1:0] sl_w_data = '0;

    // observations
    int cnt_awv = 0, cnt_wv = 0, cnt_arv = 0, rsp_count = 0, grant_cyc = 0, rsp_cyc = 0;
    int grant_q[$];
    logic [NR-1:0] last_rsp_vec = '0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 0;

    // model: outstanding obligations of the current transaction
    logic          m_busy = 0, m_aw_p = 0, m_w_p = 0, m_b_p = 0, m_ar_p = 0, m_r_p = 0;
    logic          m_rsp_due = 0, m_err = 0;
    logic [DW-1:0] m_rdata = '0;
    int            m_ptr = 0, m_idx = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [SW-1:0] m_strb = '0;

    function automatic logic [NR-1:0] onehot(input int k);
        logic [NR-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    initial begin : monitor
        logic [NR-1:0] exp_ready;
        int gk, c;
        logic o_aw, o_w, o_b, o_ar, o_r;
        forever begin
            @(negedge clk);
            cyc++;
            // slave drives this cycle
            axi_rsp.aw_ready = (sl_aw_wait >= aw_dly);
            axi_rsp.w_ready  = (sl_w_wait >= w_dly);
            axi_rsp.ar_ready = (sl_ar_wait >= ar_dly);
            axi_rsp.b_valid  = sl_b_pend && (sl_b_wait >= bv_dly);
            axi_rsp.b.id     = sl_b_id;
            axi_rsp.b.resp   = b_resp_k;
            axi_rsp.r_valid  = sl_r_pend && (sl_r_wait >= rv_dly);
            axi_rsp.r.id     = sl_ar_id;
            axi_rsp.r.data   = r_data_k;
            axi_rsp.r.resp   = r_resp_k;
            axi_rsp.r.last   = 1'b1;

            if (axi_req.aw_valid) cnt_awv++;
            if (axi_req.w_valid)  cnt_wv++;
            if (axi_req.ar_valid) cnt_arv++;
            for (int i = 0; i < NR; i++)
                if (req_ready[i]) begin grant_q.push_back(i); grant_cyc = cyc; end
            if (rsp_valid != '0) begin
                rsp_count++; rsp_cyc = cyc;
                last_rsp_vec = rsp_valid; last_rdata = rsp_rdata; last_err = rsp_err;
            end

            // expectations
            exp_ready = '0;
            gk = -1;
            if (!rst && !m_busy)
                for (int i = 0; i < NR; i++) begin
                    c = (m_ptr + i) % NR;
                    if (gk < 0 && req_valid[c]) gk = c;
                end
            if (gk >= 0) exp_ready[gk] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("aw_valid", 64'(axi_req.aw_valid), 64'(m_aw_p));
            chk("w_valid",  64'(axi_req.w_valid),  64'(m_w_p));
            chk("b_ready",  64'(axi_req.b_ready),  64'(m_b_p));
            chk("ar_valid", 64'(axi_req.ar_valid), 64'(m_ar_p));
            chk("r_ready",  64'(axi_req.r_ready),  64'(m_r_p));
            chk("rsp_valid", 64'(rsp_valid), m_rsp_due ? 64'(onehot(m_idx)) : 64'd0);
            if (m_rsp_due) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", 64'(rsp_err), 64'(m_err));
            end
            if (m_aw_p) begin
                chk("aw_addr", 64'(axi_req.aw.addr), 64'(m_addr));
                chk("aw_id", 64'(axi_req.aw.id), 64'(m_idx));
                chk("aw_len", 64'(axi_req.aw.len), 64'd0);
                chk("aw_size", 64'(axi_req.aw.size), 64'($clog2(DW / 8)));
                chk("aw_burst", 64'(axi_req.aw.burst), 64'd1);
                chk("aw_misc", 64'({axi_req.aw.lock, axi_req.aw.cache, axi_req.aw.prot,
                    axi_req.aw.qos, axi_req.aw.region, axi_req.aw.atop, axi_req.aw.user}), 64'd0);
            end
            if (m_w_p) begin
                chk("w_data", axi_req.w.data, m_wdata);
                chk("w_strb", 64'(axi_req.w.strb), 64'(m_strb));
                chk("w_last", 64'(axi_req.w.last), 64'd1);
            end
            if (m_ar_p) begin
                chk("ar_addr", 64'(axi_req.ar.addr), 64'(m_addr));
                chk("ar_id", 64'(axi_req.ar.id), 64'(m_idx));
                chk("ar_len_size_burst", 64'({axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst}),
                    64'({8'd0, 3'($clog2(DW / 8)), 2'b01}));
                chk("ar_misc", 64'({axi_req.ar.lock, axi_req.ar.cache, axi_req.ar.prot,
                    axi_req.ar.qos, axi_req.ar.region, axi_req.ar.user}), 64'd0);
            end

            // advance model and slave across the coming edge
            if (rst) begin
                m_busy = 0; m_aw_p = 0; m_w_p = 0; m_b_p = 0; m_ar_p = 0; m_r_p = 0;
                m_rsp_due = 0; m_ptr = 0;
                sl_aw_wait = 0; sl_w_wait = 0; sl_ar_wait = 0; sl_b_wait = 0; sl_r_wait = 0;
                sl_aw_done = 0; sl_w_done = 0; sl_b_pend = 0; sl_r_pend = 0;
            end else begin
                o_aw = m_aw_p; o_w = m_w_p; o_b = m_b_p; o_ar = m_ar_p; o_r = m_r_p;
                if (m_rsp_due) begin m_rsp_due = 0; m_busy = 0; end
                if (o_aw && axi_rsp.aw_ready) m_aw_p = 0;
                if (o_w && axi_rsp.w_ready) m_w_p = 0;
                if ((o_aw || o_w) && !m_aw_p && !m_w_p) m_b_p = 1;
                if (o_b && axi_rsp.b_valid) begin
                    m_b_p = 0; m_rsp_due = 1; m_rdata = '0; m_err = axi_rsp.b.resp[1];
                end
                if (o_ar && axi_rsp.ar_ready) begin m_ar_p = 0; m_r_p = 1; end
                if (o_r && axi_rsp.r_valid) begin
                    m_r_p = 0; m_rsp_due = 1; m_rdata = axi_rsp.r.data; m_err = axi_rsp.r.resp[1];
                end
                if (gk >= 0) begin
                    m_busy = 1; m_idx = gk; m_ptr = (gk + 1) % NR;
                    m_addr = req_addr[gk*AW +: AW];
                    m_wdata = req_wdata[gk*DW +: DW];
                    m_strb = req_strb[gk*SW +: SW];
                    if (req_we[gk]) begin m_aw_p = 1; m_w_p = 1; end
                    else m_ar_p = 1;
                end

                if (sl_b_pend) begin
                    if (axi_rsp.b_valid && axi_req.b_ready) sl_b_pend = 0;
                    else sl_b_wait++;
                end
                if (axi_req.aw_valid) begin
                    if (axi_rsp.aw_ready) begin
                        sl_aw_done = 1; sl_aw_wait = 0;
                        sl_aw_id = axi_req.aw.id; sl_aw_addr = axi_req.aw.addr;
                        sl_aw_len = axi_req.aw.len; sl_aw_size = axi_req.aw.size;
                    end else sl_aw_wait++;
                end
                if (axi_req.w_valid) begin
                    if (axi_rsp.w_ready) begin
                        sl_w_done = 1; sl_w_wait = 0;
                        sl_w_last = axi_req.w.last; sl_w_data = axi_req.w.data;
                    end else sl_w_wait++;
                end
                if (sl_aw_done && sl_w_done) begin
                    sl_aw_done = 0; sl_w_done = 0; sl_b_pend = 1; sl_b_wait = 0; sl_b_id = sl_aw_id;
                end
                if (sl_r_pend) begin
                    if (axi_rsp.r_valid && axi_req.r_ready) sl_r_pend = 0;
                    else sl_r_wait++;
                end
                if (axi_req.ar_valid) begin
                    if (axi_rsp.ar_ready) begin
                        sl_r_pend = 1; sl_r_wait = 0; sl_ar_wait = 0;
                        sl_ar_id = axi_req.ar.id; sl_ar_addr = axi_req.ar.addr;
                    end else sl_ar_wait++;
                end
            end
        end
    end

    task automatic clear_obs();
        cnt_awv = 0; cnt_wv = 0; cnt_arv = 0; rsp_count = 0;
        grant_q.delete();
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_we[k] = we;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
        req_strb[k*SW +: SW] = s;
        req_valid[k] = 1'b1;
    endtask

    task automatic issue(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic got;
        got = 0;
        set_req(k, we, a, d, s);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[k]) got = 1;
        end
        if (!got) timeout("issue_grant");
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int limit);
        logic done;
        done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            if (rsp_count >= n) done = 1;
        end
        if (!done) timeout("wait_rsp");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_axi_req_zero", 64'(axi_req == '0), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rdata_err", 64'({rsp_rdata != '0, rsp_err}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // single write, zero-wait
        clear_obs();
        issue(0, 1'b1, 48'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        wait_rsp(1, 50);
        chk("t1_grant_count", 64'(grant_q.size()), 64'd1);
        if (grant_q.size() > 0) chk("t1_grant_idx", 64'(grant_q[0]), 64'd0);
        chk("t1_latency", 64'(rsp_cyc - grant_cyc), 64'd3);
        chk("t1_rsp_vec", 64'(last_rsp_vec), 64'b01);
        chk("t1_err", 64'(last_err), 64'd0);
        chk("t1_rdata", last_rdata, 64'd0);
        chk("t1_aw_addr", 64'(sl_aw_addr), 64'h1000);
        chk("t1_aw_id_len_size", 64'({sl_aw_id, sl_aw_len, sl_aw_size}), 64'({4'd0, 8'd0, 3'd3}));
        chk("t1_w_last", 64'(sl_w_last), 64'd1);
        chk("t1_w_data", sl_w_data, 64'hDEADBEEF_CAFEF00D);

        // read with SLVERR
        clear_obs();
        r_data_k = 64'h55; r_resp_k = 2'b10;
        issue(1, 1'b0, 48'h2008, 64'h0, 8'h00);
        wait_rsp(1, 50);
        chk("t2_ar_id", 64'(sl_ar_id), 64'd1);
        chk("t2_ar_addr", 64'(sl_ar_addr), 64'h2008);
        chk("t2_rsp_vec", 64'(last_rsp_vec), 64'b10);
        chk("t2_rdata", last_rdata, 64'h55);
        chk("t2_err", 64'(last_err), 64'd1);
        chk("t2_latency", 64'(rsp_cyc - grant_cyc), 64'd3);

        // fairness with both requesters continuously valid
        clear_obs();
        r_data_k = 64'h1234; r_resp_k = 2'b00; b_resp_k = 2'b01;
        set_req(0, 1'b1, 48'h3000, 64'h1111_2222_3333_4444, 8'hF0);
        set_req(1, 1'b0, 48'h3100, 64'h0, 8'h00);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            if (grant_q.size() >= 6) got = 1;
        end
        #1 req_valid = '0;
        if (!got) timeout("t3_grants");
        wait_rsp(6, 100);
        chk("t3_grant_count", 64'(grant_q.size()), 64'd6);
        for (int i = 0; i < grant_q.size() && i < 6; i++)
            chk("t3_grant_order", 64'(grant_q[i]), 64'(i % 2));
        chk("t3_rsp_count", 64'(rsp_count), 64'd6);
        chk("t3_last_err", 64'(last_err), 64'd0);

        // split write handshake
        clear_obs();
        b_resp_k = 2'b00; aw_dly = 3;
        issue(1, 1'b1, 48'h4000, 64'h0123_4567_89AB_CDEF, 8'h0F);
        wait_rsp(1, 50);
        chk("t4_aw_valid_cycles", 64'(cnt_awv), 64'd4);
        chk("t4_w_valid_cycles", 64'(cnt_wv), 64'd1);
        chk("t4_latency", 64'(rsp_cyc - grant_cyc), 64'd6);
        chk("t4_rsp_count", 64'(rsp_count), 64'd1);
        chk("t4_rsp_vec", 64'(last_rsp_vec), 64'b10);

        // backpressured read, with a requester giving up mid-transaction
        clear_obs();
        aw_dly = 0; ar_dly = 4; rv_dly = 5;
        r_data_k = 64'hA5A5_5A5A_0F0F_F0F0; r_resp_k = 2'b11;
        issue(0, 1'b0, 48'h5008, 64'h0, 8'h00);
        set_req(1, 1'b1, 48'h5100, 64'h9, 8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_rsp(1, 60);
        chk("t5_ar_valid_cycles", 64'(cnt_arv), 64'd5);
        chk("t5_latency", 64'(rsp_cyc - grant_cyc), 64'd12);
        chk("t5_grant_count", 64'(grant_q.size()), 64'd1);
        chk("t5_rsp_count", 64'(rsp_count), 64'd1);
        chk("t5_rdata", last_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        chk("t5_err", 64'(last_err), 64'd1);

        // reset while waiting for B
        clear_obs();
        ar_dly = 0; rv_dly = 0; bv_dly = 20;
        issue(0, 1'b1, 48'h6000, 64'h6666, 8'h03);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_axi_req_zero", 64'(axi_req == '0), 64'd1);
        bv_dly = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_rsp", 64'(rsp_count), 64'd0);
        clear_obs();
        r_data_k = 64'h77; r_resp_k = 2'b00;
        set_req(0, 1'b0, 48'h7000, 64'h0, 8'h00);
        set_req(1, 1'b0, 48'h7100, 64'h0, 8'h00);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        if (!got) timeout("t6_grant");
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(1, 50);
        if (grant_q.size() > 0) chk("t6_grant_idx", 64'(grant_q[0]), 64'd0);
        chk("t6_rsp_vec", 64'(last_rsp_vec), 64'b01);
        chk("t6_rdata", last_rdata, 64'h77);
        chk("t6_rsp_count", 64'(rsp_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
